// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage core: load-use bubbles, branch flushes,
// data-memory wait freeze with timeout watchdog, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      inst_data_ID,
   input  logic [31:0]      inst_data_EX,
   input  logic             memread_EX,
   input  logic             branch_taken_EX,
   input  logic             dmem_req_MEM,
   input  logic             dmem_ready,
   input  logic             err_clr,
   input  logic             cnt_clr,
   output logic             stall_IF,
   output logic             stall_ID,
   output logic             stall_EX,
   output logic             stall_MEM,
   output logic             flush_ID,
   output logic             flush_EX,
   output logic             bus_err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              bus_err_q, bus_err_d;
   logic [CNT_W-1:0]  cnt_q;

   logic [6:0] opcode_id;
   logic [4:0] rd_ex, rs1_id, rs2_id;
   logic       use1, use2, luse;
   logic       freeze, eval;
   logic       stall_if_int;

   logic unused_inst_bits;
   assign unused_inst_bits = ^{inst_data_EX[31:12], inst_data_EX[6:0],
                               inst_data_ID[31:25], inst_data_ID[14:7]};

   assign opcode_id = inst_data_ID[6:0];
   assign rd_ex     = inst_data_EX[11:7];
   assign rs1_id    = inst_data_ID[19:15];
   assign rs2_id    = inst_data_ID[24:20];

   // LUI/AUIPC/JAL carry immediate bits in the rs1 field; only R/S/B read rs2.
   assign use1 = !((opcode_id == 7'b0110111) || (opcode_id == 7'b0010111) ||
                   (opcode_id == 7'b1101111));
   assign use2 = (opcode_id == 7'b0110011) || (opcode_id == 7'b0100011) ||
                 (opcode_id == 7'b1100011);
   assign luse = memread_EX && (rd_ex != 5'd0) &&
                 ((use1 && (rd_ex == rs1_id)) || (use2 && (rd_ex == rs2_id)));

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      bus_err_d = bus_err_q;
      freeze    = 1'b0;
      eval      = 1'b0;
      unique case (state_q)
         StRun: begin
            if (dmem_req_MEM && !dmem_ready) begin
               freeze  = 1'b1;
               state_d = StMemWait;
               wait_d  = WAIT_W'(1);
            end else begin
               eval = 1'b1;
            end
         end
         StMemWait: begin
            if (dmem_ready) begin
               eval    = 1'b1;
               state_d = StRun;
               wait_d  = '0;
            end else begin
               freeze = 1'b1;
               if (wait_q == WAIT_W'(TIMEOUT)) begin
                  state_d   = StError;
                  bus_err_d = 1'b1;
               end else begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end
         end
         StError: begin
            freeze = 1'b1;
            if (err_clr) begin
               bus_err_d = 1'b0;
               state_d   = StRun;
               wait_d    = '0;
            end
         end
         default: begin
            state_d = StRun;
            wait_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StRun;
         wait_q    <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Outputs are forced low while reset is asserted, even if a request is still pending.
   assign stall_if_int = freeze || (eval && !branch_taken_EX && luse);
   assign stall_IF     = rst_n && stall_if_int;
   assign stall_ID     = rst_n && stall_if_int;
   assign stall_EX     = rst_n && freeze;
   assign stall_MEM    = rst_n && freeze;
   assign flush_ID     = rst_n && eval && branch_taken_EX;
   assign flush_EX     = rst_n && eval && (branch_taken_EX || luse);
   assign bus_err      = bus_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= '0;
      end else if (stall_if_int && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; a second instance with a 4-bit counter checks saturation.
module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst_data_ID, inst_data_EX;
   logic        memread_EX, branch_taken_EX, dmem_req_MEM, dmem_ready, err_clr, cnt_clr;
   logic        stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, bus_err;
   logic [31:0] stall_cnt;
   logic        s4_if, s4_id, s4_ex, s4_mem, f4_id, f4_ex, bus_err4;
   logic [3:0]  stall_cnt4;
   logic [5:0]  outs;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] LW_X5      = 32'h0002A283;
   localparam logic [31:0] LW_X0      = 32'h0002A003;
   localparam logic [31:0] ADD_RS1_X5 = 32'h00728333;
   localparam logic [31:0] ADD_RS2_X5 = 32'h00538333;
   localparam logic [31:0] ADD_X0_X7  = 32'h00700333;
   localparam logic [31:0] LUI_RS1_5  = 32'h00028337;
   localparam logic [31:0] ADDI_IMM5  = 32'h00538313;

   localparam logic [5:0] O_NONE   = 6'b000000;
   localparam logic [5:0] O_LUSE   = 6'b110001;
   localparam logic [5:0] O_BRANCH = 6'b000011;
   localparam logic [5:0] O_FREEZE = 6'b111100;

   always #5 clk = ~clk;

   assign outs = {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX};

   hazard_stall_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .inst_data_ID(inst_data_ID), .inst_data_EX(inst_data_EX),
      .memread_EX(memread_EX), .branch_taken_EX(branch_taken_EX),
      .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready), .err_clr(err_clr),
      .cnt_clr(cnt_clr), .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
      .stall_MEM(stall_MEM), .flush_ID(flush_ID), .flush_EX(flush_EX), .bus_err(bus_err),
      .stall_cnt(stall_cnt)
   );

   hazard_stall_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .inst_data_ID(inst_data_ID), .inst_data_EX(inst_data_EX),
      .memread_EX(memread_EX), .branch_taken_EX(branch_taken_EX),
      .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready), .err_clr(err_clr),
      .cnt_clr(cnt_clr), .stall_IF(s4_if), .stall_ID(s4_id), .stall_EX(s4_ex),
      .stall_MEM(s4_mem), .flush_ID(f4_id), .flush_EX(f4_ex), .bus_err(bus_err4),
      .stall_cnt(stall_cnt4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      inst_data_ID    = 32'h0;
      inst_data_EX    = 32'h0;
      memread_EX      = 1'b0;
      branch_taken_EX = 1'b0;
      dmem_req_MEM    = 1'b0;
      dmem_ready      = 1'b0;
      err_clr         = 1'b0;
      cnt_clr         = 1'b0;
   endtask

   task automatic clear_cnt();
      idle_inputs();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
   endtask

   task automatic set_luse(input logic [31:0] ex, input logic [31:0] id, input logic rd);
      inst_data_EX = ex;
      inst_data_ID = id;
      memread_EX   = rd;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #12;
      checks++;
      if (outs !== O_NONE) begin
         errors++; $display("FAIL reset_outs: got %b expected %b", outs, O_NONE);
      end
      checks++;
      if (stall_cnt !== 32'd0 || bus_err !== 1'b0) begin
         errors++; $display("FAIL reset_regs: got cnt=%0d err=%b expected 0/0", stall_cnt, bus_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_load_use();
      clear_cnt();
      set_luse(LW_X5, ADD_RS1_X5, 1'b1);
      #1;
      checks++;
      if (outs !== O_LUSE) begin
         errors++; $display("FAIL luse_rs1: got %b expected %b", outs, O_LUSE);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (outs !== O_NONE || stall_cnt !== 32'd1) begin
         errors++; $display("FAIL luse_one_bubble: got %b cnt=%0d expected %b cnt=1",
                            outs, stall_cnt, O_NONE);
      end
   endtask

   task automatic test_no_false_stall();
      clear_cnt();
      set_luse(LW_X5, LUI_RS1_5, 1'b1);
      #1;
      checks++;
      if (outs !== O_NONE) begin
         errors++; $display("FAIL lui_no_rs1: got %b expected %b", outs, O_NONE);
      end
      tick();
      set_luse(LW_X0, ADD_X0_X7, 1'b1);
      #1;
      checks++;
      if (outs !== O_NONE) begin
         errors++; $display("FAIL load_rd_x0: got %b expected %b", outs, O_NONE);
      end
      tick();
      set_luse(LW_X5, ADDI_IMM5, 1'b1);
      #1;
      checks++;
      if (outs !== O_NONE) begin
         errors++; $display("FAIL itype_no_rs2: got %b expected %b", outs, O_NONE);
      end
      tick();
      set_luse(LW_X5, ADD_RS1_X5, 1'b0);
      #1;
      checks++;
      if (outs !== O_NONE) begin
         errors++; $display("FAIL not_load: got %b expected %b", outs, O_NONE);
      end
      tick();
      set_luse(LW_X5, ADD_RS2_X5, 1'b1);
      #1;
      checks++;
      if (outs !== O_LUSE) begin
         errors++; $display("FAIL luse_rs2: got %b expected %b", outs, O_LUSE);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (stall_cnt !== 32'd1) begin
         errors++; $display("FAIL no_false_cnt: got %0d expected 1", stall_cnt);
      end
   endtask

   task automatic test_branch_vs_luse();
      clear_cnt();
      set_luse(LW_X5, ADD_RS1_X5, 1'b1);
      branch_taken_EX = 1'b1;
      #1;
      checks++;
      if (outs !== O_BRANCH) begin
         errors++; $display("FAIL branch_beats_luse: got %b expected %b", outs, O_BRANCH);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (stall_cnt !== 32'd0) begin
         errors++; $display("FAIL branch_cnt: got %0d expected 0", stall_cnt);
      end
   endtask

   task automatic test_mem_wait();
      clear_cnt();
      dmem_req_MEM = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (outs !== O_FREEZE) begin
            errors++; $display("FAIL wait_freeze_%0d: got %b expected %b", i, outs, O_FREEZE);
         end
         tick();
      end
      dmem_ready = 1'b1;
      #1;
      checks++;
      if (outs !== O_NONE) begin
         errors++; $display("FAIL wait_release: got %b expected %b", outs, O_NONE);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (outs !== O_NONE || stall_cnt !== 32'd3) begin
         errors++; $display("FAIL wait_after: got %b cnt=%0d expected %b cnt=3",
                            outs, stall_cnt, O_NONE);
      end
      // Release with a load-use pending in the same cycle
      dmem_req_MEM = 1'b1;
      tick();
      dmem_ready = 1'b1;
      set_luse(LW_X5, ADD_RS1_X5, 1'b1);
      #1;
      checks++;
      if (outs !== O_LUSE) begin
         errors++; $display("FAIL release_luse: got %b expected %b", outs, O_LUSE);
      end
      tick();
      idle_inputs();
      // Ready in the same cycle as the request: no freeze, stay in RUN
      dmem_req_MEM = 1'b1;
      dmem_ready   = 1'b1;
      #1;
      checks++;
      if (outs !== O_NONE) begin
         errors++; $display("FAIL ready_same_cycle: got %b expected %b", outs, O_NONE);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (outs !== O_NONE) begin
         errors++; $display("FAIL ready_same_cycle_run: got %b expected %b", outs, O_NONE);
      end
   endtask

   task automatic test_timeout();
      clear_cnt();
      dmem_req_MEM = 1'b1;
      for (int i = 0; i < 16; i++) tick();
      checks++;
      if (bus_err !== 1'b0) begin
         errors++; $display("FAIL timeout_early: got %b expected 0", bus_err);
      end
      tick();
      dmem_req_MEM = 1'b0;
      #1;
      checks++;
      if (bus_err !== 1'b1 || outs !== O_FREEZE) begin
         errors++; $display("FAIL timeout_err: got err=%b outs=%b expected 1/%b",
                            bus_err, outs, O_FREEZE);
      end
      tick();
      err_clr = 1'b1;
      #1;
      checks++;
      if (outs !== O_FREEZE || bus_err !== 1'b1) begin
         errors++; $display("FAIL err_clr_same_cycle: got outs=%b err=%b expected %b/1",
                            outs, bus_err, O_FREEZE);
      end
      tick();
      err_clr = 1'b0;
      #1;
      checks++;
      if (outs !== O_NONE || bus_err !== 1'b0) begin
         errors++; $display("FAIL err_clr_next: got outs=%b err=%b expected %b/0",
                            outs, bus_err, O_NONE);
      end
      checks++;
      if (stall_cnt !== 32'd19) begin
         errors++; $display("FAIL timeout_cnt: got %0d expected 19", stall_cnt);
      end
   endtask

   task automatic test_cnt_clr();
      clear_cnt();
      set_luse(LW_X5, ADD_RS1_X5, 1'b1);
      tick();
      cnt_clr = 1'b1;
      tick();
      idle_inputs();
      #1;
      checks++;
      if (stall_cnt !== 32'd0) begin
         errors++; $display("FAIL cnt_clr_wins: got %0d expected 0", stall_cnt);
      end
   endtask

   task automatic test_saturation();
      clear_cnt();
      set_luse(LW_X5, ADD_RS1_X5, 1'b1);
      for (int i = 0; i < 20; i++) tick();
      idle_inputs();
      #1;
      checks++;
      if (stall_cnt4 !== 4'd15) begin
         errors++; $display("FAIL saturate_4b: got %0d expected 15", stall_cnt4);
      end
      checks++;
      if (stall_cnt !== 32'd20) begin
         errors++; $display("FAIL count_32b: got %0d expected 20", stall_cnt);
      end
   endtask

   task automatic test_reset_mid_wait();
      idle_inputs();
      dmem_req_MEM = 1'b1;
      tick();
      tick();
      checks++;
      if (outs !== O_FREEZE) begin
         errors++; $display("FAIL pre_reset_freeze: got %b expected %b", outs, O_FREEZE);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (outs !== O_NONE || stall_cnt !== 32'd0) begin
         errors++; $display("FAIL async_reset: got %b cnt=%0d expected %b cnt=0",
                            outs, stall_cnt, O_NONE);
      end
      @(negedge clk);
      dmem_req_MEM = 1'b0;
      rst_n = 1'b1;
      tick();
      checks++;
      if (outs !== O_NONE) begin
         errors++; $display("FAIL reset_to_run: got %b expected %b", outs, O_NONE);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_false_stall();
      test_branch_vs_luse();
      test_mem_wait();
      test_timeout();
      test_cnt_clr();
      test_saturation();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
